cell_array_ctrl: RTL

CELL_ARRAY_CTRL -- requirements
Module: cell_array_ctrl

---
 rtl/cell_array_pkg.sv | 16 +
 rtl/onehot_dec.sv | 12 +
 rtl/cell_array_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/cell_array_pkg.sv
// Shared definitions for the binary-cell array controller: default geometry
// and the controller state encoding.
package cell_array_pkg;

  localparam int AW_DEF    = 3;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_RESP  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot row decoder; the enable gating is left to the caller.
module onehot_dec #(
  parameter int AW    = 3,
  parameter int WORDS = 2**AW
) (
  input  logic [AW-1:0]    sel,
  output logic [WORDS-1:0] onehot
);

  assign onehot = WORDS'(1) << sel;

endmodule

// File: rtl/cell_array_ctrl.sv
// Controller for a row-addressed binary-cell array: single-word writes,
// registered reads with a valid/ready response, and a whole-array zero-fill.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Once
// raised, rsp_valid and rsp_rdata hold until that transfer.
module cell_array_ctrl
  import cell_array_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORDS = 2**AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [AW-1:0]          req_addr,
  input  logic [WIDTH-1:0]       req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_rdata,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic [WORDS-1:0]       cell_cs,
  output logic                   cell_w,
  output logic                   cell_r,
  output logic [WIDTH-1:0]       cell_din,
  input  logic [WORDS*WIDTH-1:0] cell_dout
);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    cnt_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             accept;
  logic             row_en;
  logic [AW-1:0]    row_sel;
  logic [WORDS-1:0] row_onehot;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Counter wraps to zero after the last row, ready for the next fill.
      if (state_q == S_CLEAR) cnt_q <= cnt_q + 1'b1;
      else                    cnt_q <= '0;
      if (state_q == S_READ)
        rdata_q <= cell_dout[int'(addr_q)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    clr_busy  = 1'b0;
    cell_w    = 1'b0;
    cell_r    = 1'b0;
    cell_din  = '0;
    row_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
        end else begin
          req_ready = 1'b1;
          if (req_valid) state_d = req_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        row_en   = 1'b1;
        cell_w   = 1'b1;
        cell_din = wdata_q;
        state_d  = S_IDLE;
      end
      S_READ: begin
        row_en  = 1'b1;
        cell_r  = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      S_CLEAR: begin
        row_en   = 1'b1;
        cell_w   = 1'b1;
        clr_busy = 1'b1;
        if (cnt_q == AW'(WORDS-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign row_sel = (state_q == S_CLEAR) ? cnt_q : addr_q;

  onehot_dec #(.AW(AW), .WORDS(WORDS)) u_dec (
    .sel    (row_sel),
    .onehot (row_onehot)
  );

  assign cell_cs   = row_en ? row_onehot : '0;
  assign rsp_rdata = rdata_q;

endmodule
